// File: rtl/pattern_pkg.sv
// Constants shared by the pattern generator and checker: frame sizes,
// expected frame contents and the receive-state encoding.
package pattern_pkg;
  localparam int SIZESRDYN  = 16;
  localparam int SIZESRSTAT = 88;

  localparam logic [15:0] EXP_DYN  = 16'hABCD;
  localparam logic [87:0] EXP_STAT = 88'h123456789ABCDEF1234567;

  typedef enum logic [1:0] {IDLE, RX_DYN, RX_STAT, ABORT} state_e;
endpackage

// File: rtl/pattern_checker_rx_lane.sv
// One receive lane: MSB-first shift register, saturating bit counter and
// compare against the lane's fixed expected pattern.
module rx_lane #(
  parameter int              SIZE     = 16,
  parameter int              CNTW     = 7,
  parameter logic [SIZE-1:0] EXPECTED = '0
) (
  input  logic            CLK,
  input  logic            RST_N,
  input  logic            start_i,
  input  logic            shift_i,
  input  logic            ser_i,
  output logic [SIZE-1:0] shift_o,
  output logic            len_ok_o,
  output logic            match_o
);
  localparam logic [CNTW-1:0] CNT_FULL = CNTW'(SIZE);
  localparam logic [CNTW-1:0] CNT_SAT  = CNTW'(SIZE + 1);

  logic [SIZE-1:0] shift_q, shift_d;
  logic [CNTW-1:0] cnt_q, cnt_d;

  // A new frame clears stale bits so short frames read back zero-filled.
  always_comb begin
    shift_d = shift_q;
    cnt_d   = cnt_q;
    if (start_i) begin
      shift_d = {{(SIZE-1){1'b0}}, ser_i};
      cnt_d   = CNTW'(1);
    end else if (shift_i) begin
      shift_d = {shift_q[SIZE-2:0], ser_i};
      if (cnt_q != CNT_SAT) cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      shift_q <= '0;
      cnt_q   <= '0;
    end else begin
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
    end
  end

  assign shift_o  = shift_q;
  assign len_ok_o = (cnt_q == CNT_FULL);
  assign match_o  = len_ok_o && (shift_q == EXPECTED);
endmodule

// File: rtl/pattern_checker.sv
// Serial frame checker for the dynamic/static pattern link.
// Define PATTERN_CHECKER_ERR_CNT_EN to build the saturating ERR_CNT counter.
module pattern_checker #(
  parameter int SIZESRSTAT = pattern_pkg::SIZESRSTAT,
  parameter int SIZESRDYN  = pattern_pkg::SIZESRDYN,
  parameter int CNTW       = 7
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  SER_IN,
  input  logic                  SELDYN_IN,
  input  logic                  SELSTAT_IN,
  output logic [SIZESRDYN-1:0]  DYN_WORD,
  output logic [SIZESRSTAT-1:0] STAT_WORD,
  output logic                  DYN_VALID,
  output logic                  STAT_VALID,
  output logic                  FRAME_OK,
  output logic                  LEN_ERR,
  output logic                  PROTO_ERR,
  output logic [7:0]            ERR_CNT
);
  import pattern_pkg::*;

  state_e state_q, state_d;
  logic dyn_start, dyn_shift, stat_start, stat_shift;
  logic [SIZESRDYN-1:0]  dyn_sr, dword_q, dword_d;
  logic [SIZESRSTAT-1:0] stat_sr, sword_q, sword_d;
  logic dyn_len_ok, dyn_match, stat_len_ok, stat_match;
  logic dv_q, dv_d, sv_q, sv_d, ok_q, ok_d, le_q, le_d, pe_q, pe_d;
  logic both;

  rx_lane #(.SIZE(SIZESRDYN), .CNTW(CNTW), .EXPECTED(SIZESRDYN'(EXP_DYN))) u_dyn (
    .CLK(CLK), .RST_N(RST_N), .start_i(dyn_start), .shift_i(dyn_shift),
    .ser_i(SER_IN), .shift_o(dyn_sr), .len_ok_o(dyn_len_ok), .match_o(dyn_match));

  rx_lane #(.SIZE(SIZESRSTAT), .CNTW(CNTW), .EXPECTED(SIZESRSTAT'(EXP_STAT))) u_stat (
    .CLK(CLK), .RST_N(RST_N), .start_i(stat_start), .shift_i(stat_shift),
    .ser_i(SER_IN), .shift_o(stat_sr), .len_ok_o(stat_len_ok), .match_o(stat_match));

  assign both = SELDYN_IN && SELSTAT_IN;

  always_comb begin
    state_d    = state_q;
    dyn_start  = 1'b0;
    dyn_shift  = 1'b0;
    stat_start = 1'b0;
    stat_shift = 1'b0;
    dv_d = 1'b0; sv_d = 1'b0; ok_d = 1'b0; le_d = 1'b0; pe_d = 1'b0;
    dword_d = dword_q;
    sword_d = sword_q;
    case (state_q)
      IDLE: begin
        if (both)            begin state_d = ABORT;   pe_d = 1'b1;       end
        else if (SELDYN_IN)  begin state_d = RX_DYN;  dyn_start = 1'b1;  end
        else if (SELSTAT_IN) begin state_d = RX_STAT; stat_start = 1'b1; end
      end
      RX_DYN: begin
        if (both)           begin state_d = ABORT; pe_d = 1'b1; end
        else if (SELDYN_IN) dyn_shift = 1'b1;
        else begin
          // Close; a static select on this same edge is that frame's bit 0.
          dv_d = 1'b1; le_d = !dyn_len_ok; ok_d = dyn_match; dword_d = dyn_sr;
          if (SELSTAT_IN) begin state_d = RX_STAT; stat_start = 1'b1; end
          else state_d = IDLE;
        end
      end
      RX_STAT: begin
        if (both)            begin state_d = ABORT; pe_d = 1'b1; end
        else if (SELSTAT_IN) stat_shift = 1'b1;
        else begin
          sv_d = 1'b1; le_d = !stat_len_ok; ok_d = stat_match; sword_d = stat_sr;
          if (SELDYN_IN) begin state_d = RX_DYN; dyn_start = 1'b1; end
          else state_d = IDLE;
        end
      end
      ABORT:   if (!SELDYN_IN && !SELSTAT_IN) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      dword_q <= '0; sword_q <= '0;
      dv_q <= 1'b0; sv_q <= 1'b0; ok_q <= 1'b0; le_q <= 1'b0; pe_q <= 1'b0;
    end else begin
      state_q <= state_d;
      dword_q <= dword_d; sword_q <= sword_d;
      dv_q <= dv_d; sv_q <= sv_d; ok_q <= ok_d; le_q <= le_d; pe_q <= pe_d;
    end
  end

  assign DYN_WORD   = dword_q;
  assign STAT_WORD  = sword_q;
  assign DYN_VALID  = dv_q;
  assign STAT_VALID = sv_q;
  assign FRAME_OK   = ok_q;
  assign LEN_ERR    = le_q;
  assign PROTO_ERR  = pe_q;

`ifdef PATTERN_CHECKER_ERR_CNT_EN
  logic [7:0] err_q;
  logic       err_inc;

  // Counted on next-state so ERR_CNT moves together with the pulse it counts.
  assign err_inc = ((dv_d || sv_d) && !ok_d) || pe_d;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)                          err_q <= '0;
    else if (err_inc && err_q != 8'hFF)  err_q <= err_q + 8'd1;
  end

  assign ERR_CNT = err_q;
`else
  assign ERR_CNT = 8'h00;
`endif
endmodule
